fp_writeback_arbiter: RTL and testbench
=======================================

// Module: fp_writeback_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 FP register file between two writeback sources:
//  the FPU result path and the GPR->FP move/load path (mtc1/lwc1).
//  - One-entry holding slot per source; round-robin arbitration; registered drive of RF write port.
//  - 32-bit pending-write scoreboard reserved at issue and released on RF write.
//  - Combinational hazard signal so issue logic stalls on RAW/WAW against in-flight FP writes.
// PARAMETERS
//  DATA_W    32  width of FP register data
//  ADDR_W    5   register index width
//  NUM_REGS  32  number of FP registers (= 2**ADDR_W)
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  issue_valid    in   1       FP-writing instruction presented for issue
//  issue_reg      in   ADDR_W  destination FP register of that instruction
//  src_a_reg      in   ADDR_W  first FP source operand of that instruction
//  src_b_reg      in   ADDR_W  second FP source operand of that instruction
//  hazard         out  1       issue must stall this cycle (combinational)
//  fpu_valid      in   1       FPU result available
//  fpu_ready      out  1       FPU slot empty, result accepted this edge if valid
//  fpu_reg        in   ADDR_W  FPU result destination
//  fpu_data       in   DATA_W  FPU result value
//  mov_valid      in   1       move/load result available
//  mov_ready      out  1       move slot empty
//  mov_reg        in   ADDR_W  move/load destination
//  mov_data       in   DATA_W  move/load value
//  rf_write_enable out 1       to FP register file write_enable
//  rf_write_reg   out  ADDR_W  to FP register file write_reg
//  rf_write_data  out  DATA_W  to FP register file write_data
//  pending        out  NUM_REGS scoreboard, bit r = write to register r outstanding
//  orphan_err     out  1       sticky: RF write issued to a register not pending
// BEHAVIOUR
//  - Reset: slots empty, pending=0, rf_write_enable=0, rf_write_reg=0, rf_write_data=0,
//    orphan_err=0, last_grant=MOV (FPU wins first tie). Reset mid-operation discards held
//    entries and reservations; sources must re-present after reset.
//  - Handshake per source: ready = ~slot_full (registered state only, no input->ready path).
//    Transfer on valid&&ready at edge; reg/data captured into slot. valid with ready=0 is held
//    by the source; data must stay stable.
//  - Arbitration each cycle over full slots: one full -> grant it; both full -> grant source
//    not in last_grant; update last_grant only on a grant.
//  - Granted slot empties at the edge. rf_write_* register at the same edge: enable=1,
//    reg/data from slot. No grant -> enable=0, reg/data hold previous value.
//  - Latency: accept at edge N -> rf_write_enable high in cycle after edge N+1 -> RF writes at
//    edge N+2. Freed slot reports ready the cycle after grant: 1 transfer per 2 cycles per
//    source, 1 RF write per cycle aggregate.
//  - hazard = issue_valid & (pending[src_a_reg] | pending[src_b_reg] | pending[issue_reg]).
//    Driven from registered pending only; in-flight write in current cycle still a hazard.
//  - Scoreboard: issue_valid & ~hazard sets pending[issue_reg] at edge.
//    rf_write_enable clears pending[rf_write_reg] at edge.
//    Same register set and cleared in same cycle: set wins.
//  - rf_write_enable with pending[rf_write_reg]=0: write still performed, orphan_err set
//    (sticky until reset).
//  - Register 0 is an ordinary FP register; no special casing.
// STRUCTURE
//  - Shared package fp_wb_pkg: DATA_W, ADDR_W, NUM_REGS, source ids SRC_FPU=0, SRC_MOV=1.
//  - Sub-module wb_hold_slot, instantiated twice: one-entry valid/ready buffer with
//    load/release; arbiter, output regs and scoreboard stay in the top.
// TESTING
//  1. Reset, then fpu_valid, reg=3, data=0x3F800000 with pending[3] preset via issue ->
//     rf_write_enable 2 cycles later, reg=3, data=0x3F800000; pending[3] cleared next edge.
//  2. Both slots full same cycle (fpu reg 1, mov reg 2) after reset -> fpu writes first,
//     mov next cycle; repeat -> order alternates from last_grant.
//  3. pending[5]=1; issue_valid, src_a_reg=5 -> hazard=1, pending unchanged;
//     issue_reg=5 (WAW) -> hazard=1.
//  4. Write to reg 7 clears pending[7] same edge as new issue to 7 -> pending[7]=1 after edge.
//  5. mov write to reg 9 with pending[9]=0 -> RF written, orphan_err=1, stays 1 until reset.
//  6. fpu_valid held 4 cycles with slot full -> fpu_ready=0 until grant, no data loss.
//     Reset asserted with both slots full -> next cycle both ready=1, enable=0, pending=0.

Source files
------------

// File: rtl/fp_wb_pkg.sv
// Shared widths and writeback source ids for the FP register-file writeback path.
package fp_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_MOV = 1'b1
  } src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding buffer: captures reg/data on a valid/ready transfer, empties on drain.
// Latency: the entry is visible the cycle after the transfer. Backpressure: ready = ~full, from state only.
module wb_hold_slot #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              full,
  output logic [ADDR_W-1:0] slot_reg,
  output logic [DATA_W-1:0] slot_data
);

  assign in_ready = ~full;

  // drain is only raised while full, and loading needs the slot empty, so the two never coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= 1'b0;
      slot_reg  <= '0;
      slot_data <= '0;
    end else if (in_valid && in_ready) begin
      full      <= 1'b1;
      slot_reg  <= in_reg;
      slot_data <= in_data;
    end else if (drain) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Round-robin arbiter sharing the FP register-file write port between the FPU and move/load paths,
// with a pending-write scoreboard and combinational RAW/WAW hazard. Latency: accept -> RF write 2 edges later.
// Backpressure: each source sees ready only while its one-entry slot is empty.
module fp_writeback_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DATA_W   = fp_wb_pkg::DATA_W,
  parameter int ADDR_W   = fp_wb_pkg::ADDR_W,
  parameter int NUM_REGS = fp_wb_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  input  logic [ADDR_W-1:0]   src_a_reg,
  input  logic [ADDR_W-1:0]   src_b_reg,
  output logic                hazard,
  input  logic                fpu_valid,
  output logic                fpu_ready,
  input  logic [ADDR_W-1:0]   fpu_reg,
  input  logic [DATA_W-1:0]   fpu_data,
  input  logic                mov_valid,
  output logic                mov_ready,
  input  logic [ADDR_W-1:0]   mov_reg,
  input  logic [DATA_W-1:0]   mov_data,
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] pending,
  output logic                orphan_err
);

  logic              fpu_full, mov_full;
  logic [ADDR_W-1:0] fpu_slot_reg, mov_slot_reg;
  logic [DATA_W-1:0] fpu_slot_data, mov_slot_data;
  logic              grant_fpu, grant_mov;
  src_e              last_grant;

  wb_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fpu_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fpu_valid),
    .in_ready  (fpu_ready),
    .in_reg    (fpu_reg),
    .in_data   (fpu_data),
    .drain     (grant_fpu),
    .full      (fpu_full),
    .slot_reg  (fpu_slot_reg),
    .slot_data (fpu_slot_data)
  );

  wb_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mov_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mov_valid),
    .in_ready  (mov_ready),
    .in_reg    (mov_reg),
    .in_data   (mov_data),
    .drain     (grant_mov),
    .full      (mov_full),
    .slot_reg  (mov_slot_reg),
    .slot_data (mov_slot_data)
  );

  // On a tie the source that did not win last time is granted
  always_comb begin
    grant_fpu = fpu_full && (!mov_full || last_grant == SRC_MOV);
    grant_mov = mov_full && (!fpu_full || last_grant == SRC_FPU);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant      <= SRC_MOV;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= grant_fpu || grant_mov;
      if (grant_fpu) begin
        last_grant    <= SRC_FPU;
        rf_write_reg  <= fpu_slot_reg;
        rf_write_data <= fpu_slot_data;
      end else if (grant_mov) begin
        last_grant    <= SRC_MOV;
        rf_write_reg  <= mov_slot_reg;
        rf_write_data <= mov_slot_data;
      end
    end
  end

  assign hazard = issue_valid &&
                  (pending[src_a_reg] || pending[src_b_reg] || pending[issue_reg]);

  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && !hazard) set_mask[issue_reg]    = 1'b1;
    if (rf_write_enable)        clr_mask[rf_write_reg] = 1'b1;
  end

  // A new reservation outranks the release of the same register in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      orphan_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (rf_write_enable && !pending[rf_write_reg]) orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed self-checking bench for fp_writeback_arbiter with hand-computed expectations.
module tb_fp_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_reg, src_a_reg, src_b_reg;
  logic        hazard;
  logic        fpu_valid, fpu_ready;
  logic [4:0]  fpu_reg;
  logic [31:0] fpu_data;
  logic        mov_valid, mov_ready;
  logic [4:0]  mov_reg;
  logic [31:0] mov_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending;
  logic        orphan_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_writeback_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_reg       (issue_reg),
    .src_a_reg       (src_a_reg),
    .src_b_reg       (src_b_reg),
    .hazard          (hazard),
    .fpu_valid       (fpu_valid),
    .fpu_ready       (fpu_ready),
    .fpu_reg         (fpu_reg),
    .fpu_data        (fpu_data),
    .mov_valid       (mov_valid),
    .mov_ready       (mov_ready),
    .mov_reg         (mov_reg),
    .mov_data        (mov_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .pending         (pending),
    .orphan_err      (orphan_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_reg   = '0;
    src_a_reg   = '0;
    src_b_reg   = '0;
    fpu_valid   = 1'b0;
    mov_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1'b1;
    issue_reg   = r;
    src_a_reg   = r;
    src_b_reg   = r;
    tick();
    idle();
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_en"},   32'(rf_write_enable), 32'd1);
    check({tag, "_reg"},  32'(rf_write_reg),    32'(r));
    check({tag, "_data"}, rf_write_data,        d);
  endtask

  // Both sources present together; fpu_first selects the expected winner of the tie
  task automatic pair(input logic [31:0] fd, input logic [31:0] md, input logic fpu_first);
    issue(5'd1);
    issue(5'd2);
    fpu_valid = 1'b1; fpu_reg = 5'd1; fpu_data = fd;
    mov_valid = 1'b1; mov_reg = 5'd2; mov_data = md;
    tick();
    idle();
    #1;
    check("pair_fpu_busy", 32'(fpu_ready), 32'd0);
    check("pair_mov_busy", 32'(mov_ready), 32'd0);
    tick();
    if (fpu_first) expect_write("pair_w1", 5'd1, fd);
    else           expect_write("pair_w1", 5'd2, md);
    tick();
    if (fpu_first) expect_write("pair_w2", 5'd2, md);
    else           expect_write("pair_w2", 5'd1, fd);
    tick();
    check("pair_idle_en", 32'(rf_write_enable), 32'd0);
    check("pair_pending", pending, 32'h0);
  endtask

  initial begin
    fpu_reg = '0; fpu_data = '0; mov_reg = '0; mov_data = '0;

    // 1: reset state and single FPU write latency
    do_reset();
    check("rst_fpu_ready", 32'(fpu_ready),       32'd1);
    check("rst_mov_ready", 32'(mov_ready),       32'd1);
    check("rst_en",        32'(rf_write_enable), 32'd0);
    check("rst_reg",       32'(rf_write_reg),    32'd0);
    check("rst_data",      rf_write_data,        32'd0);
    check("rst_pending",   pending,              32'd0);
    check("rst_orphan",    32'(orphan_err),      32'd0);

    issue_valid = 1'b1; issue_reg = 5'd3; src_a_reg = 5'd3; src_b_reg = 5'd3;
    #1;
    check("t1_issue_hazard", 32'(hazard), 32'd0);
    tick();
    idle();
    #1;
    check("t1_pending_set", pending, 32'h8);
    fpu_valid = 1'b1; fpu_reg = 5'd3; fpu_data = 32'h3F80_0000;
    tick();
    idle();
    #1;
    check("t1_fpu_busy", 32'(fpu_ready),       32'd0);
    check("t1_en_early", 32'(rf_write_enable), 32'd0);
    tick();
    expect_write("t1_w", 5'd3, 32'h3F80_0000);
    check("t1_pending_hold", pending,          32'h8);
    check("t1_fpu_free",     32'(fpu_ready),   32'd1);
    tick();
    check("t1_en_off",      32'(rf_write_enable), 32'd0);
    check("t1_pending_clr", pending,              32'h0);
    check("t1_reg_hold",    32'(rf_write_reg),    32'd3);
    check("t1_data_hold",   rf_write_data,        32'h3F80_0000);
    check("t1_orphan",      32'(orphan_err),      32'd0);

    // 2: simultaneous sources, round-robin order
    do_reset();
    pair(32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
    pair(32'hAAAA_0003, 32'hBBBB_0004, 1'b1);
    issue(5'd1);
    fpu_valid = 1'b1; fpu_reg = 5'd1; fpu_data = 32'hCCCC_0005;
    tick();
    idle();
    tick();
    expect_write("t2_single", 5'd1, 32'hCCCC_0005);
    tick();
    pair(32'hAAAA_0006, 32'hBBBB_0007, 1'b0);
    check("t2_orphan", 32'(orphan_err), 32'd0);

    // 3: RAW and WAW hazards against pending[5]
    issue(5'd5);
    check("t3_pending", pending, 32'h20);
    issue_valid = 1'b1; issue_reg = 5'd10; src_a_reg = 5'd5; src_b_reg = 5'd11;
    #1;
    check("t3_raw_a", 32'(hazard), 32'd1);
    tick();
    check("t3_pending_unch", pending, 32'h20);
    issue_reg = 5'd14; src_a_reg = 5'd12; src_b_reg = 5'd5;
    #1;
    check("t3_raw_b", 32'(hazard), 32'd1);
    issue_reg = 5'd5; src_a_reg = 5'd12; src_b_reg = 5'd13;
    #1;
    check("t3_waw", 32'(hazard), 32'd1);
    issue_valid = 1'b0;
    #1;
    check("t3_no_issue", 32'(hazard), 32'd0);
    tick();
    check("t3_pending_end", pending, 32'h20);

    // 4: release and new reservation of reg 7 on the same edge
    do_reset();
    fpu_valid = 1'b1; fpu_reg = 5'd7; fpu_data = 32'h0000_0777;
    tick();
    idle();
    tick();
    expect_write("t4_w", 5'd7, 32'h0000_0777);
    issue_valid = 1'b1; issue_reg = 5'd7; src_a_reg = 5'd7; src_b_reg = 5'd7;
    #1;
    check("t4_hazard", 32'(hazard), 32'd0);
    tick();
    idle();
    #1;
    check("t4_pending", pending, 32'h80);

    // 5: orphan move write to reg 9 is sticky
    do_reset();
    check("t5_orphan_rst", 32'(orphan_err), 32'd0);
    mov_valid = 1'b1; mov_reg = 5'd9; mov_data = 32'h9999_0009;
    tick();
    idle();
    tick();
    expect_write("t5_w", 5'd9, 32'h9999_0009);
    check("t5_orphan_pre", 32'(orphan_err), 32'd0);
    tick();
    check("t5_orphan_set", 32'(orphan_err), 32'd1);
    check("t5_pending",    pending,         32'h0);
    tick();
    tick();
    check("t5_orphan_sticky", 32'(orphan_err), 32'd1);
    do_reset();
    check("t5_orphan_clr", 32'(orphan_err), 32'd0);

    // 6: FPU valid held across a busy slot, then reset with both slots full
    issue(5'd4);
    fpu_valid = 1'b1; fpu_reg = 5'd4; fpu_data = 32'h4000_000A;
    #1;
    check("t6_c0_ready", 32'(fpu_ready), 32'd1);
    tick();
    fpu_data = 32'h4000_000B;
    #1;
    check("t6_c1_ready", 32'(fpu_ready),       32'd0);
    check("t6_c1_en",    32'(rf_write_enable), 32'd0);
    tick();
    check("t6_c2_ready", 32'(fpu_ready), 32'd1);
    expect_write("t6_wA", 5'd4, 32'h4000_000A);
    tick();
    fpu_data = 32'h4000_000C;
    #1;
    check("t6_c3_ready", 32'(fpu_ready),       32'd0);
    check("t6_c3_en",    32'(rf_write_enable), 32'd0);
    tick();
    idle();
    #1;
    expect_write("t6_wB", 5'd4, 32'h4000_000B);
    check("t6_c4_ready", 32'(fpu_ready), 32'd1);
    tick();

    fpu_valid = 1'b1; fpu_reg = 5'd8; fpu_data = 32'h8888_0008;
    mov_valid = 1'b1; mov_reg = 5'd9; mov_data = 32'h9999_0009;
    issue_valid = 1'b1; issue_reg = 5'd20; src_a_reg = 5'd20; src_b_reg = 5'd20;
    tick();
    idle();
    #1;
    check("t6_full_fpu", 32'(fpu_ready), 32'd0);
    check("t6_full_mov", 32'(mov_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_fpu_ready", 32'(fpu_ready),       32'd1);
    check("t6_rst_mov_ready", 32'(mov_ready),       32'd1);
    check("t6_rst_en",        32'(rf_write_enable), 32'd0);
    check("t6_rst_pending",   pending,              32'h0);
    tick();
    check("t6_rst_no_write",  32'(rf_write_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
